// File: rtl/fp_pkg.sv
// Shared constants and helpers for the single-precision multiply back end.
//   EXP_W / MAN_W / BIAS : IEEE-754 single field widths and exponent bias
//   PW                   : width of the significand product (hidden bits included)
//   QNAN / EXP_MAX       : canonical quiet NaN and the all-ones exponent code
//   pack()               : assemble sign|exponent|fraction into a 32-bit word
package fp_pkg;

  localparam int EXP_W   = 8;
  localparam int MAN_W   = 23;
  localparam int BIAS    = 127;
  localparam int PW      = 2 * (MAN_W + 1);
  localparam int EXP_MAX = 255;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  function automatic logic [31:0] pack(input logic             sign,
                                       input logic [EXP_W-1:0] exp,
                                       input logic [MAN_W-1:0] frac);
    return {sign, exp, frac};
  endfunction

endpackage

// File: rtl/fp_round_rne.sv
// Round-to-nearest-even on a normalised fraction.
//   frac    : 23-bit fraction (hidden bit excluded)
//   g, s    : guard bit and sticky OR of everything below it
//   e       : 10-bit signed biased exponent
//   frac_r  : rounded fraction
//   e_r     : exponent, bumped when rounding carries out of the fraction
//   inexact : any discarded bit was nonzero
module fp_round_rne
  import fp_pkg::*;
(
  input  logic                    [MAN_W-1:0] frac,
  input  logic                                g,
  input  logic                                s,
  input  logic signed             [EXP_W+1:0] e,
  output logic                    [MAN_W-1:0] frac_r,
  output logic signed             [EXP_W+1:0] e_r,
  output logic                                inexact
);

  localparam logic signed [EXP_W+1:0] ONE_S = 1;

  // Ties go to the even fraction: only round up on a tie when the LSB is odd.
  function automatic logic rne_inc(input logic lsb, input logic gd, input logic st);
    return gd & (st | lsb);
  endfunction

  logic [MAN_W:0] sum;

  always_comb begin
    sum     = {1'b0, frac} + {{MAN_W{1'b0}}, rne_inc(frac[0], g, s)};
    inexact = g | s;
    if (sum[MAN_W]) begin
      // 1.111..1 + ulp = 10.000..0: renormalise by one position.
      frac_r = '0;
      e_r    = e + ONE_S;
    end else begin
      frac_r = sum[MAN_W-1:0];
      e_r    = e;
    end
  end

endmodule

// File: rtl/fp32_mul_normround.sv
// Back end of the single-precision multiplier: normalises the 48-bit
// significand product, rounds to nearest-even, range-checks and packs.
// Two-stage pipeline with valid/ready on both sides.
//   clk, rst_n                : clock, asynchronous active-low reset
//   in_valid / in_ready       : input handshake
//   in_sign, in_exp_a/b       : result sign, biased operand exponents
//   in_prod                   : 48-bit significand product
//   in_zero/in_inf/in_nan     : operand class flags
//   out_valid / out_ready     : output handshake
//   out_result                : packed IEEE-754 single
//   out_ovf/out_unf/out_inexact : overflow, flush-to-zero underflow, inexact
module fp32_mul_normround
  import fp_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_sign,
  input  logic [EXP_W-1:0]    in_exp_a,
  input  logic [EXP_W-1:0]    in_exp_b,
  input  logic [PW-1:0]       in_prod,
  input  logic                in_zero,
  input  logic                in_inf,
  input  logic                in_nan,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [31:0]         out_result,
  output logic                out_ovf,
  output logic                out_unf,
  output logic                out_inexact
);

  localparam int EW = EXP_W + 2;
  localparam logic signed [EW-1:0] ONE_S  = 1;
  localparam logic signed [EW-1:0] ZERO_S = 0;
  localparam logic signed [EW-1:0] BIAS_S = EW'(BIAS);
  localparam logic signed [EW-1:0] EMAX_S = EW'(EXP_MAX);

  // ---- stage 0 -> 1 : normalise ----
  logic signed [EW-1:0]    e_base_p0, e_p0;
  logic        [MAN_W-1:0] frac_p0;
  logic                    g_p0, s_p0;

  assign e_base_p0 = $signed({2'b00, in_exp_a}) + $signed({2'b00, in_exp_b}) - BIAS_S;

  always_comb begin
    if (in_prod[PW-1]) begin
      frac_p0 = in_prod[PW-2:MAN_W+1];
      g_p0    = in_prod[MAN_W];
      s_p0    = |in_prod[MAN_W-1:0];
      e_p0    = e_base_p0 + ONE_S;
    end else begin
      frac_p0 = in_prod[PW-3:MAN_W];
      g_p0    = in_prod[MAN_W-1];
      s_p0    = |in_prod[MAN_W-2:0];
      e_p0    = e_base_p0;
    end
  end

  logic                    vld_p1_q, vld_p2_q;
  logic                    sign_p1_q, g_p1_q, s_p1_q;
  logic                    zero_p1_q, inf_p1_q, nan_p1_q;
  logic signed [EW-1:0]    e_p1_q;
  logic        [MAN_W-1:0] frac_p1_q;
  logic                    adv_p2;

  assign adv_p2   = !vld_p2_q || out_ready;
  assign in_ready = !vld_p1_q || adv_p2;

  // Payload registers carry no reset; the valid bits qualify them.
  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      sign_p1_q <= in_sign;
      e_p1_q    <= e_p0;
      frac_p1_q <= frac_p0;
      g_p1_q    <= g_p0;
      s_p1_q    <= s_p0;
      zero_p1_q <= in_zero;
      inf_p1_q  <= in_inf;
      nan_p1_q  <= in_nan;
    end
  end

  // ---- stage 1 -> 2 : round, range-check, pack ----
  logic        [MAN_W-1:0] frac_r_p1;
  logic signed [EW-1:0]    e_r_p1;
  logic                    inx_r_p1;

  fp_round_rne u_round (
    .frac    (frac_p1_q),
    .g       (g_p1_q),
    .s       (s_p1_q),
    .e       (e_p1_q),
    .frac_r  (frac_r_p1),
    .e_r     (e_r_p1),
    .inexact (inx_r_p1)
  );

  logic [31:0] res_d, res_q;
  logic        ovf_d, unf_d, inx_d;
  logic        ovf_q, unf_q, inx_q;

  always_comb begin
    res_d = pack(sign_p1_q, e_r_p1[EXP_W-1:0], frac_r_p1);
    ovf_d = 1'b0;
    unf_d = 1'b0;
    inx_d = inx_r_p1;
    if (nan_p1_q || (inf_p1_q && zero_p1_q)) begin
      res_d = QNAN;
      inx_d = 1'b0;
    end else if (inf_p1_q) begin
      res_d = pack(sign_p1_q, '1, '0);
      inx_d = 1'b0;
    end else if (zero_p1_q) begin
      res_d = pack(sign_p1_q, '0, '0);
      inx_d = 1'b0;
    end else if (e_r_p1 >= EMAX_S) begin
      res_d = pack(sign_p1_q, '1, '0);
      ovf_d = 1'b1;
      inx_d = 1'b1;
    end else if (e_r_p1 <= ZERO_S) begin
      // No subnormal output: anything below the normal range flushes to zero.
      res_d = pack(sign_p1_q, '0, '0);
      unf_d = 1'b1;
      inx_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
      res_q    <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      inx_q    <= 1'b0;
    end else begin
      if (in_ready) vld_p1_q <= in_valid;
      if (adv_p2) begin
        vld_p2_q <= vld_p1_q;
        if (vld_p1_q) begin
          res_q <= res_d;
          ovf_q <= ovf_d;
          unf_q <= unf_d;
          inx_q <= inx_d;
        end
      end
    end
  end

  assign out_valid   = vld_p2_q;
  assign out_result  = res_q;
  assign out_ovf     = ovf_q;
  assign out_unf     = unf_q;
  assign out_inexact = inx_q;

endmodule

// File: tb/tb_fp32_mul_normround.sv
module tb_fp32_mul_normround;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_sign;
  logic [7:0]  in_exp_a, in_exp_b;
  logic [47:0] in_prod;
  logic        in_zero, in_inf, in_nan;
  logic        out_valid, out_ready;
  logic [31:0] out_result;
  logic        out_ovf, out_unf, out_inexact;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fp32_mul_normround dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_sign     (in_sign),
    .in_exp_a    (in_exp_a),
    .in_exp_b    (in_exp_b),
    .in_prod     (in_prod),
    .in_zero     (in_zero),
    .in_inf      (in_inf),
    .in_nan      (in_nan),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_ovf     (out_ovf),
    .out_unf     (out_unf),
    .out_inexact (out_inexact)
  );

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [34:0] outv();
    return {out_ovf, out_unf, out_inexact, out_result};
  endfunction

  // Reference: value = prod * 2^(ea+eb-2*BIAS-46); round the integer product
  // to a 24-bit significand by direct remainder comparison.
  function automatic logic [34:0] model(input logic sg, input logic [7:0] ea, input logic [7:0] eb,
                                        input logic [47:0] p, input logic z, input logic inf,
                                        input logic nan);
    longint P, kept, rem, half;
    int     msb, sh, e;
    logic   inex;
    if (nan || (inf && z)) return {3'b000, 32'h7FC00000};
    if (inf) return {3'b000, sg, 8'hFF, 23'd0};
    if (z)   return {3'b000, sg, 31'd0};
    P   = longint'(p);
    msb = 0;
    for (int i = 0; i < 48; i++) if (p[i]) msb = i;
    sh   = msb - 23;
    kept = P >> sh;
    rem  = P - (kept << sh);
    half = longint'(1) << (sh - 1);
    inex = (rem != 0);
    if (rem > half || (rem == half && kept[0])) kept++;
    e = int'(ea) + int'(eb) - 127 + (msb - 46);
    if (kept == (longint'(1) << 24)) begin
      kept = kept >> 1;
      e++;
    end
    if (e >= 255) return {3'b101, sg, 8'hFF, 23'd0};
    if (e <= 0)   return {3'b011, sg, 31'd0};
    return {2'b00, inex, sg, e[7:0], kept[22:0]};
  endfunction

  task automatic drive(input logic sg, input logic [7:0] ea, input logic [7:0] eb,
                       input logic [47:0] p, input logic z, input logic inf, input logic nan);
    in_sign = sg; in_exp_a = ea; in_exp_b = eb; in_prod = p;
    in_zero = z; in_inf = inf; in_nan = nan;
  endtask

  task automatic do_single(input string tag, input logic sg, input logic [7:0] ea,
                           input logic [7:0] eb, input logic [47:0] p, input logic z,
                           input logic inf, input logic nan, input logic [34:0] expv);
    @(negedge clk);
    drive(sg, ea, eb, p, z, inf, nan);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    #1 chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk({tag, "_lat1"}, 64'(out_valid), 64'd0);
    @(negedge clk);
    #1 chk({tag, "_lat2"}, 64'(out_valid), 64'd1);
    chk(tag, 64'(outv()), 64'(expv));
  endtask

  logic [47:0] bp_prod [3] = '{48'h900000000000, 48'hD20000000000, 48'h400000C00000};
  logic [7:0]  bp_ea   [3] = '{8'd127, 8'd129, 8'd127};
  logic [7:0]  bp_eb   [3] = '{8'd127, 8'd130, 8'd127};
  logic [34:0] bp_exp  [3] = '{35'h040100000, 35'h042D20000, 35'h13F800002};

  logic [34:0] q [$];
  logic [34:0] held_val, popped;
  logic        held, stalled;
  logic [31:0] r;
  logic [23:0] ma, mb;
  int          k, sel;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    drive(1'b0, 8'd0, 8'd0, 48'd0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    #1 chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_outputs", 64'(outv()), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    #1 chk("post_reset_in_ready", 64'(in_ready), 64'd1);

    // Directed values
    do_single("mul_1p5_sq", 1'b0, 8'd127, 8'd127, 48'h900000000000, 1'b0, 1'b0, 1'b0, 35'h040100000);
    do_single("mul_7x15",   1'b0, 8'd129, 8'd130, 48'hD20000000000, 1'b0, 1'b0, 1'b0, 35'h042D20000);
    do_single("tie_even",   1'b0, 8'd127, 8'd127, 48'h400000400000, 1'b0, 1'b0, 1'b0, 35'h13F800000);
    do_single("tie_odd",    1'b0, 8'd127, 8'd127, 48'h400000C00000, 1'b0, 1'b0, 1'b0, 35'h13F800002);
    do_single("round_carry",1'b0, 8'd127, 8'd127, 48'hFFFFFF800000, 1'b0, 1'b0, 1'b0, 35'h140800000);
    do_single("overflow",   1'b1, 8'd254, 8'd254, 48'h400000000000, 1'b0, 1'b0, 1'b0, 35'h5FF800000);
    do_single("underflow",  1'b0, 8'd1,   8'd1,   48'h400000000000, 1'b0, 1'b0, 1'b0, 35'h300000000);
    do_single("inf_x_zero", 1'b0, 8'd255, 8'd0,   48'h0,            1'b1, 1'b1, 1'b0, 35'h07FC00000);
    do_single("inf_neg",    1'b1, 8'd255, 8'd127, 48'h400000000000, 1'b0, 1'b1, 1'b0, 35'h0FF800000);
    do_single("nan",        1'b0, 8'd255, 8'd127, 48'h400000000000, 1'b0, 1'b0, 1'b1, 35'h07FC00000);
    do_single("zero_neg",   1'b1, 8'd0,   8'd127, 48'h0,            1'b1, 1'b0, 1'b0, 35'h080000000);

    // Backpressure: three beats offered, consumer stalled
    @(negedge clk);
    out_ready = 1'b0;
    k = 0;
    for (int c = 0; c < 5; c++) begin
      drive(1'b0, bp_ea[k], bp_eb[k], bp_prod[k], 1'b0, 1'b0, 1'b0);
      in_valid = 1'b1;
      #1 chk($sformatf("bp_in_ready_c%0d", c), 64'(in_ready), (c < 2) ? 64'd1 : 64'd0);
      if (c >= 2) begin
        chk($sformatf("bp_hold_valid_c%0d", c), 64'(out_valid), 64'd1);
        chk($sformatf("bp_hold_c%0d", c), 64'(outv()), 64'(bp_exp[0]));
      end
      if (in_ready) k++;
      @(negedge clk);
    end
    chk("bp_accepted", 64'(k), 64'd2);
    out_ready = 1'b1;
    #1 chk("bp_rel_in_ready", 64'(in_ready), 64'd1);
    chk("bp_rel_0", 64'(outv()), 64'(bp_exp[0]));
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk("bp_rel_1_valid", 64'(out_valid), 64'd1);
    chk("bp_rel_1", 64'(outv()), 64'(bp_exp[1]));
    @(negedge clk);
    #1 chk("bp_rel_2_valid", 64'(out_valid), 64'd1);
    chk("bp_rel_2", 64'(outv()), 64'(bp_exp[2]));
    @(negedge clk);
    #1 chk("bp_drained", 64'(out_valid), 64'd0);

    // Reset while a result is waiting at the output
    out_ready = 1'b0;
    @(negedge clk);
    drive(1'b0, 8'd127, 8'd127, 48'h900000000000, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #1 chk("rst_mid_pre_valid", 64'(out_valid), 64'd1);
    #1 rst_n = 1'b0;
    #1 chk("rst_mid_async_valid", 64'(out_valid), 64'd0);
    chk("rst_mid_async_out", 64'(outv()), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1 chk($sformatf("rst_no_stale_c%0d", c), 64'(out_valid), 64'd0);
    end
    do_single("rst_after", 1'b0, 8'd129, 8'd130, 48'hD20000000000, 1'b0, 1'b0, 1'b0, 35'h042D20000);

    // Randomised streaming against the reference model
    held = 1'b0; stalled = 1'b0; held_val = '0;
    @(negedge clk);
    in_valid = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (!stalled) begin
        r = $urandom(); ma = {1'b1, r[22:0]};
        r = $urandom(); mb = {1'b1, r[22:0]};
        sel = $urandom_range(0, 3);
        if ($urandom_range(0, 3) == 0) begin
          r = $urandom();
          in_prod = {24'hFFFFFF, r[23:0]};
        end else begin
          in_prod = {24'd0, ma} * {24'd0, mb};
        end
        case (sel)
          1: begin in_exp_a = 8'($urandom_range(1, 10));    in_exp_b = 8'($urandom_range(110, 130)); end
          2: begin in_exp_a = 8'($urandom_range(240, 254)); in_exp_b = 8'($urandom_range(120, 140)); end
          default: begin in_exp_a = 8'($urandom_range(1, 254)); in_exp_b = 8'($urandom_range(1, 254)); end
        endcase
        in_sign  = 1'($urandom_range(0, 1));
        in_zero  = ($urandom_range(0, 11) == 0);
        in_inf   = ($urandom_range(0, 11) == 0);
        in_nan   = ($urandom_range(0, 15) == 0);
        in_valid = ($urandom_range(0, 3) != 0);
      end
      out_ready = ($urandom_range(0, 9) < 7);
      #1;
      if (held) begin
        chk("rnd_hold_valid", 64'(out_valid), 64'd1);
        chk("rnd_hold", 64'(outv()), 64'(held_val));
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("rnd_spurious", 64'(out_valid), 64'd0);
        else begin
          popped = q.pop_front();
          chk("rnd_result", 64'(outv()), 64'(popped));
        end
      end
      held     = out_valid && !out_ready;
      held_val = outv();
      if (in_valid && in_ready)
        q.push_back(model(in_sign, in_exp_a, in_exp_b, in_prod, in_zero, in_inf, in_nan));
      stalled = in_valid && !in_ready;
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (out_valid) begin
        if (q.size() == 0) chk("drain_spurious", 64'(out_valid), 64'd0);
        else begin
          popped = q.pop_front();
          chk("drain_result", 64'(outv()), 64'(popped));
        end
      end
      @(negedge clk);
    end
    chk("rnd_queue_empty", 64'(q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
